rpsc_fault_latch: RTL

- Fault-capture card feeding the RF-permit card. It produces the latched fault flip-flop signals ff1..ff6 that the permit card ORs into RF_perm_b and RF_red_b.
- Raw field fault contacts are synchronized, debounced and latched.
- The first fault is recorded. The alarm output is driven.
- Latches clear only on an operator reset request, and only when every fault has gone away.

---
 rtl/rpsc_fault_pkg.sv | 20 ++
 rtl/rpsc_fault_latch_if.sv | 25 ++
 rtl/rpsc_fault_qual.sv | 40 ++++
 rtl/rpsc_fault_latch.sv | 114 +++++++++++
 4 files changed

// File: rtl/rpsc_fault_pkg.sv
// Shared types and helpers for the RF-permit fault-capture card.
package rpsc_fault_pkg;

  localparam int NUM_FAULTS_DEF = 6;
  localparam logic [2:0] FF_NONE = 3'd0;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2
  } state_t;

  // Returns lowest set index + 1, or FF_NONE when no bit is set.
  function automatic logic [2:0] lowest_code(input logic [6:0] v);
    lowest_code = FF_NONE;
    for (int i = 6; i >= 0; i--)
      if (v[i]) lowest_code = 3'(i + 1);
  endfunction

endpackage

// File: rtl/rpsc_fault_latch_if.sv
// Field-side bundle of the fault latch: raw contacts, operator buttons, latched status.
interface rpsc_fault_latch_if
  import rpsc_fault_pkg::*;
#(
  parameter int NUM_FAULTS = NUM_FAULTS_DEF
);
  logic [NUM_FAULTS-1:0] i_fault_raw;
  logic                  i_rst_req_b;
  logic                  i_lamp_test_b;
  logic [NUM_FAULTS-1:0] o_ff;
  logic                  o_alarm_b;
  logic [2:0]            o_first_fault;
  logic                  o_reset_reject;
  logic                  o_armed;

  modport master (
    output i_fault_raw, i_rst_req_b, i_lamp_test_b,
    input  o_ff, o_alarm_b, o_first_fault, o_reset_reject, o_armed
  );

  modport slave (
    input  i_fault_raw, i_rst_req_b, i_lamp_test_b,
    output o_ff, o_alarm_b, o_first_fault, o_reset_reject, o_armed
  );
endinterface

// File: rtl/rpsc_fault_qual.sv
// One fault channel: 2-flop synchronizer plus saturating debounce counter.
module rpsc_fault_qual
  import rpsc_fault_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter bit MASK         = 1'b0
) (
  input  logic clk,
  input  logic reset_b,
  input  logic i_raw,
  output logic o_qual,
  output logic o_busy
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYC);

  logic          r_s1, r_s2;
  logic [CW-1:0] r_cnt;

  // Any low sample drops the count at once; a fault must be continuous to qualify.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (!r_s2)
        r_cnt <= '0;
      else if (r_cnt != CMAX)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // A disabled channel must not veto an operator reset either.
  assign o_qual = (r_cnt == CMAX) & ~MASK;
  assign o_busy = (r_cnt != '0) & ~MASK;

endmodule

// File: rtl/rpsc_fault_latch.sv
// Fault-capture card: qualifies field faults, latches ff1..ffN, records first fault.
module rpsc_fault_latch
  import rpsc_fault_pkg::*;
#(
  parameter int                    NUM_FAULTS   = NUM_FAULTS_DEF,
  parameter int                    DEBOUNCE_CYC = 4,
  parameter int                    HOLDOFF_CYC  = 8,
  parameter logic [NUM_FAULTS-1:0] FAULT_MASK   = '0
) (
  input  logic               clk,
  input  logic               reset_b,
  rpsc_fault_latch_if.slave  bus
);
  localparam int HW = $clog2(HOLDOFF_CYC + 1);

  logic [NUM_FAULTS-1:0] w_qual, w_busy, w_ff_nxt;
  logic                  w_press, w_accept, w_lamp;

  state_t                r_state;
  logic [HW-1:0]         r_hold;
  logic [NUM_FAULTS-1:0] r_ff;
  logic [2:0]            r_first;
  logic                  r_reject, r_armed, r_alarm_b;
  logic [2:0]            r_rst_s;   // [0],[1] sync, [2] previous synced value
  logic [1:0]            r_lamp_s;

  for (genvar g = 0; g < NUM_FAULTS; g++) begin : g_ch
    rpsc_fault_qual #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .MASK         (FAULT_MASK[g])
    ) u_qual (
      .clk     (clk),
      .reset_b (reset_b),
      .i_raw   (bus.i_fault_raw[g]),
      .o_qual  (w_qual[g]),
      .o_busy  (w_busy[g])
    );
  end

  // Buttons idle high, so their synchronizers reset to 1 to avoid a phantom press/lamp.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_rst_s  <= 3'b111;
      r_lamp_s <= 2'b11;
    end else begin
      r_rst_s  <= {r_rst_s[1:0], bus.i_rst_req_b};
      r_lamp_s <= {r_lamp_s[0], bus.i_lamp_test_b};
    end
  end

  assign w_press  = r_rst_s[2] & ~r_rst_s[1];
  assign w_lamp   = ~r_lamp_s[1];
  assign w_accept = (r_state == TRIPPED) & w_press & ~(|w_qual) & ~(|w_busy);
  // r_ff is zero in CLEAR/ARMED, so OR-ing qual covers every state's latch rule.
  assign w_ff_nxt = w_accept ? '0 : (r_ff | w_qual);

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_state   <= CLEAR;
      r_hold    <= HW'(HOLDOFF_CYC);
      r_ff      <= '0;
      r_first   <= FF_NONE;
      r_reject  <= 1'b0;
      r_armed   <= 1'b0;
      r_alarm_b <= 1'b1;
    end else begin
      r_reject  <= 1'b0;
      r_ff      <= w_ff_nxt;
      r_alarm_b <= ~(|w_ff_nxt | w_lamp);
      case (r_state)
        CLEAR: begin
          if (|w_qual) begin
            r_state <= TRIPPED;
            r_first <= lowest_code(7'(w_qual));
          end else if (r_hold <= HW'(1)) begin
            r_hold  <= '0;
            r_state <= ARMED;
            r_armed <= 1'b1;
          end else begin
            r_hold <= r_hold - HW'(1);
          end
        end
        ARMED: begin
          if (|w_qual) begin
            r_state <= TRIPPED;
            r_first <= lowest_code(7'(w_qual));
            r_armed <= 1'b0;
          end
        end
        TRIPPED: begin
          if (w_accept) begin
            r_state <= CLEAR;
            r_hold  <= HW'(HOLDOFF_CYC);
            r_first <= FF_NONE;
          end else if (w_press) begin
            r_reject <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_hold  <= HW'(HOLDOFF_CYC);
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ff           = r_ff;
  assign bus.o_alarm_b      = r_alarm_b;
  assign bus.o_first_fault  = r_first;
  assign bus.o_reset_reject = r_reject;
  assign bus.o_armed        = r_armed;

endmodule
